// File: rtl/mux_pkg.sv
// Shared definitions for the registered source-select mux: parameter checks,
// select-code helpers and source classification.
`default_nettype none

package mux_pkg;

  // Ceiling log2 used to check that the select field can address every source.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // The narrow source always occupies the code just above the full-width inputs.
  function automatic int sel_narrow(input int num_in);
    return num_in;
  endfunction

  typedef enum logic [1:0] {
    SRC_WIDE    = 2'd0,
    SRC_NARROW  = 2'd1,
    SRC_ILLEGAL = 2'd2
  } src_kind_e;

endpackage

`default_nettype wire

// File: rtl/skid_buf2.sv
// Generic 2-entry valid/ready register pair: main register drives the output,
// skid register catches the word accepted while the consumer stalls.
`default_nettype none

module skid_buf2
  import mux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t m_q, s_q, m_d, s_d;
  entry_t new_entry;
  logic   rdy_q;
  logic   acc, pop;

  assign acc       = in_valid & rdy_q;
  assign pop       = m_q.valid & out_ready;
  assign new_entry = '{valid: 1'b1, data: in_data};

  always_comb begin
    m_d = m_q;
    s_d = s_q;
    if (!m_q.valid || pop) begin
      if (s_q.valid) begin
        m_d       = s_q;
        s_d.valid = 1'b0;
        if (acc) s_d = new_entry;
      end else if (acc) begin
        m_d = new_entry;
      end else begin
        m_d.valid = 1'b0;
      end
    end else if (acc) begin
      s_d = new_entry;
    end
  end

  // Ready is registered from the next skid state so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q   <= '0;
      s_q   <= '0;
      rdy_q <= 1'b1;
    end else begin
      m_q   <= m_d;
      s_q   <= s_d;
      rdy_q <= !s_d.valid;
    end
  end

  assign in_ready  = rdy_q;
  assign out_data  = m_q.data;
  assign out_valid = m_q.valid;

endmodule

`default_nettype wire

// File: rtl/mux_sel_skid.sv
// Registered source mux: picks one of NUM_IN words or the zero-extended narrow
// field, buffers it behind a 2-entry skid, and flags illegal select codes.
`default_nettype none

module mux_sel_skid
  import mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_IN   = 2,
  parameter int NARROW_W = 2,
  parameter int SEL_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [NARROW_W-1:0]     in_narrow,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr
);

  localparam logic [SEL_W-1:0] SEL_NARROW = SEL_W'(sel_narrow(NUM_IN));

  if (SEL_W < clog2(NUM_IN + 1) || NARROW_W > WIDTH) begin : g_bad_params
    $error("mux_sel_skid: SEL_W too small for NUM_IN+1 codes, or NARROW_W > WIDTH");
  end

  logic [WIDTH-1:0] narrow_ext;
  logic [WIDTH-1:0] sel_data;
  src_kind_e        kind;
  logic             acc;

  assign narrow_ext = WIDTH'(in_narrow);

  // Codes above the narrow slot still forward the narrow field, but are flagged.
  always_comb begin
    sel_data = narrow_ext;
    kind     = (sel > SEL_NARROW) ? SRC_ILLEGAL : SRC_NARROW;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        sel_data = in_bus[k*WIDTH +: WIDTH];
        kind     = SRC_WIDE;
      end
    end
  end

  assign acc = in_valid & in_ready;

  // Set has priority over clear so an illegal accept is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (acc && kind == SRC_ILLEGAL) begin
      sel_err <= 1'b1;
    end else if (err_clr) begin
      sel_err <= 1'b0;
    end
  end

  skid_buf2 #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (sel_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

endmodule

`default_nettype wire

// File: tb/tb_mux_sel_skid.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// directed literal checks and a second instance with swept parameters.
`default_nettype none

module tb_mux_sel_skid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_bus = '0;
  logic [1:0]  in_narrow = '0;
  logic [1:0]  sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        sel_err;
  logic        err_clr = 1'b0;

  logic [79:0] p2_bus;
  logic [3:0]  p2_narrow = '0;
  logic [2:0]  p2_sel = '0;
  logic        p2_in_valid = 1'b0;
  logic        p2_in_ready;
  logic [15:0] p2_out_data;
  logic        p2_out_valid;
  logic        p2_out_ready = 1'b1;
  logic        p2_sel_err;
  logic        p2_err_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux_sel_skid dut (
    .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .in_narrow(in_narrow), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err), .err_clr(err_clr)
  );

  mux_sel_skid #(.WIDTH(16), .NUM_IN(5), .NARROW_W(4), .SEL_W(3)) dut_p2 (
    .clk(clk), .rst_n(rst_n), .in_bus(p2_bus), .in_narrow(p2_narrow), .sel(p2_sel),
    .in_valid(p2_in_valid), .in_ready(p2_in_ready), .out_data(p2_out_data),
    .out_valid(p2_out_valid), .out_ready(p2_out_ready), .sel_err(p2_sel_err),
    .err_clr(p2_err_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue of at most two words and a sticky flag.
  logic [7:0] mq[$];
  logic       m_err;

  function automatic logic [7:0] spec_word(input logic [1:0] s, input logic [15:0] bus,
                                           input logic [1:0] nar);
    if (s == 2'd0) return bus[7:0];
    if (s == 2'd1) return bus[15:8];
    return {6'b0, nar};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      logic acc_m, pop_m;
      acc_m = in_valid && (mq.size() < 2);
      pop_m = (mq.size() > 0) && out_ready;
      if (pop_m) void'(mq.pop_front());
      if (acc_m) mq.push_back(spec_word(sel, in_bus, in_narrow));
      if (acc_m && sel == 2'd3) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) chk("model_out_data", 32'(out_data), 32'(mq[0]));
      chk("model_in_ready", 32'(in_ready), 32'(mq.size() < 2));
      chk("model_sel_err", 32'(sel_err), 32'(m_err));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s);
    sel = s;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic p2_send(input logic [2:0] s, input logic [3:0] nar);
    p2_sel = s;
    p2_narrow = nar;
    p2_in_valid = 1'b1;
    cycle();
    p2_in_valid = 1'b0;
  endtask

  initial begin
    int accepted;
    int guard;
    logic rdy_before;
    p2_bus = {16'hBEEF, 16'h4444, 16'h3333, 16'h2222, 16'h1111};

    #12;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_data", 32'(out_data), 32'd0);
    chk("reset_sel_err", 32'(sel_err), 32'd0);
    rst_n = 1'b1;
    cycle();

    // Basic select, one result per cycle.
    in_bus = {8'hA5, 8'h3C};
    in_narrow = 2'b10;
    out_ready = 1'b1;
    sel = 2'd0; in_valid = 1'b1; cycle();
    chk("sel0", 32'(out_data), 32'h3C);
    sel = 2'd1; cycle();
    chk("sel1", 32'(out_data), 32'hA5);
    sel = 2'd2; cycle();
    chk("sel2", 32'(out_data), 32'h02);
    in_valid = 1'b0; cycle();
    chk("drained", 32'(out_valid), 32'd0);

    // Illegal select and sticky error.
    in_narrow = 2'b01;
    send(2'd3);
    chk("illegal_data", 32'(out_data), 32'h01);
    chk("illegal_err", 32'(sel_err), 32'd1);
    for (int i = 0; i < 5; i++) begin
      send(2'd0);
      chk("err_sticky", 32'(sel_err), 32'd1);
    end
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    chk("err_cleared", 32'(sel_err), 32'd0);
    err_clr = 1'b1; send(2'd3); err_clr = 1'b0;
    chk("err_set_wins", 32'(sel_err), 32'd1);
    err_clr = 1'b1; cycle(); err_clr = 1'b0;

    // Backpressure into the skid entry.
    out_ready = 1'b0;
    in_bus = {8'h00, 8'h11}; send(2'd0);
    chk("bp_first", 32'(out_data), 32'h11);
    chk("bp_ready1", 32'(in_ready), 32'd1);
    in_bus = {8'h00, 8'h22}; send(2'd0);
    chk("bp_ready0", 32'(in_ready), 32'd0);
    chk("bp_hold", 32'(out_data), 32'h11);
    cycle();
    chk("bp_hold2", 32'(out_data), 32'h11);
    out_ready = 1'b1; cycle();
    chk("bp_second", 32'(out_data), 32'h22);
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    cycle();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Streaming with random stalls; the per-cycle model tracks order.
    accepted = 0;
    guard = 0;
    in_valid = 1'b1;
    while (accepted < 20 && guard < 200) begin
      in_bus = {8'(8'h80 + accepted), 8'(accepted + 1)};
      in_narrow = 2'(accepted);
      sel = 2'(accepted % 3);
      out_ready = 1'($urandom_range(0, 1));
      rdy_before = in_ready;
      cycle();
      if (rdy_before) accepted++;
      guard++;
    end
    in_valid = 1'b0;
    chk("stream_count", 32'(accepted), 32'd20);
    out_ready = 1'b1;
    cycle(); cycle(); cycle();
    chk("stream_drained", 32'(out_valid), 32'd0);

    // Parameter-swept instance.
    p2_send(3'd5, 4'hF);
    chk("p2_sel5", 32'(p2_out_data), 32'h000F);
    chk("p2_err0", 32'(p2_sel_err), 32'd0);
    p2_send(3'd6, 4'hF);
    chk("p2_sel6", 32'(p2_out_data), 32'h000F);
    chk("p2_err6", 32'(p2_sel_err), 32'd1);
    p2_err_clr = 1'b1; cycle(); p2_err_clr = 1'b0;
    chk("p2_err_clr", 32'(p2_sel_err), 32'd0);
    p2_send(3'd7, 4'hF);
    chk("p2_sel7", 32'(p2_out_data), 32'h000F);
    chk("p2_err7", 32'(p2_sel_err), 32'd1);
    p2_send(3'd4, 4'h0);
    chk("p2_sel4", 32'(p2_out_data), 32'hBEEF);
    p2_send(3'd1, 4'h0);
    chk("p2_sel1", 32'(p2_out_data), 32'h2222);

    // Asynchronous reset with both entries full.
    out_ready = 1'b0;
    in_narrow = 2'b11;
    send(2'd3);
    send(2'd2);
    chk("pre_reset_full", 32'(in_ready), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    chk("async_out_data", 32'(out_data), 32'd0);
    chk("async_sel_err", 32'(sel_err), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    cycle();
    in_bus = {8'h00, 8'h5A};
    send(2'd0);
    chk("post_reset", 32'(out_data), 32'h5A);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
